axil_sig_dumper: RTL and testbench

AXIL_SIG_DUMPER -- requirements
Module: axil_sig_dumper

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_sig_dumper.sv | 140 ++++++++++++++
 tb/tb_axil_sig_dumper.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the signature dumper.
// Holds the dumper FSM state encoding and the AXI response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAr   = 3'd1,
    StR    = 3'd2,
    StOut  = 3'd3,
    StFin  = 3'd4
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/axil_sig_dumper.sv
// Signature dumper: reads the word-aligned region [sig_begin, sig_end) over an
// AXI-Lite master read channel, one read at a time, and streams each word out
// on a valid/ready interface with its index and a last marker.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle dump request (ignored while busy)
//   sig_begin, sig_end    byte range, begin inclusive, end exclusive
//   busy, done, error     status; done is a one-cycle pulse, error is sticky
//   m_axil_ar*, m_axil_r* AXI-Lite read address / read data channels
//   m_axil_aw*, w*, b*    AXI-Lite write channels, held idle
//   sig_data/valid/ready/last/index  signature word stream
module axil_sig_dumper
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] sig_begin,
  input  logic [ADDR_WIDTH-1:0] sig_end,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [31:0]           sig_data,
  output logic                  sig_valid,
  input  logic                  sig_ready,
  output logic                  sig_last,
  output logic [23:0]           sig_index
);

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [31:0]           r_data;
  logic                  r_last;
  logic [23:0]           r_index;
  logic                  r_error;

  logic [ADDR_WIDTH-1:0] w_begin_al;
  logic [ADDR_WIDTH-1:0] w_end_al;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic                  w_unused;

  // Range bounds are truncated to word alignment.
  assign w_begin_al = {sig_begin[ADDR_WIDTH-1:2], 2'b00};
  assign w_end_al   = {sig_end[ADDR_WIDTH-1:2], 2'b00};
  assign w_addr_inc = r_addr + ADDR_WIDTH'(4);

  // Write channel inputs and the sub-word address bits are not used.
  assign w_unused = ^{m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
                      sig_begin[1:0], sig_end[1:0]};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = (w_begin_al >= w_end_al) ? StFin : StAr;
      StAr:    if (m_axil_arready) w_state_next = StR;
      StR:     if (m_axil_rvalid) w_state_next = StOut;
      StOut:   if (sig_ready) w_state_next = r_last ? StFin : StAr;
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_end   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_index <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && start) begin
        r_addr  <= w_begin_al;
        r_end   <= w_end_al;
        r_last  <= 1'b0;
        r_index <= '0;
        r_error <= 1'b0;
      end
      if (r_state == StR && m_axil_rvalid) begin
        r_data <= m_axil_rdata[31:0];
        // Computed on the unadvanced address so it stays fixed through OUT.
        r_last <= (w_addr_inc >= r_end);
        if (m_axil_rresp != RespOkay) r_error <= 1'b1;
      end
      if (r_state == StOut && sig_ready) begin
        r_addr  <= w_addr_inc;
        r_index <= r_index + 24'd1;
      end
    end
  end

  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StFin);
  assign error          = r_error;
  assign m_axil_araddr  = r_addr;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = (r_state == StAr);
  assign m_axil_rready  = (r_state == StR);
  assign sig_data       = r_data;
  assign sig_valid      = (r_state == StOut);
  assign sig_last       = r_last;
  assign sig_index      = r_index;

  assign m_axil_awaddr  = '0;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = 1'b0;
  assign m_axil_wdata   = '0;
  assign m_axil_wstrb   = '0;
  assign m_axil_wvalid  = 1'b0;
  assign m_axil_bready  = 1'b1;

endmodule

// File: tb/tb_axil_sig_dumper.sv
// Self-checking bench for axil_sig_dumper. A behavioural AXI-Lite RAM slave and
// stream consumer run on the falling edge; scenario tasks compare the recorded
// traffic against a reference list of words computed from the requested range.
module tb_axil_sig_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] sig_begin;
  logic [31:0] sig_end;
  logic        busy, done, error;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = 2'b00;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp = 2'b00;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;
  logic [31:0] sig_data;
  logic        sig_valid;
  logic        sig_ready = 1'b0;
  logic        sig_last;
  logic [23:0] sig_index;

  always #5 clk = ~clk;

  axil_sig_dumper dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sig_begin      (sig_begin),
    .sig_end        (sig_end),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .sig_data       (sig_data),
    .sig_valid      (sig_valid),
    .sig_ready      (sig_ready),
    .sig_last       (sig_last),
    .sig_index      (sig_index)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [23:0] index;
    logic        last;
  } word_t;

  int errors = 0;
  int checks = 0;

  // RAM contents and reference model
  logic [31:0] mem [logic [31:0]];
  word_t       exp_words[$];
  logic [31:0] exp_addrs[$];
  logic        exp_err;

  // Addresses at or above 0x0800_0000 are unmapped: the interconnect answers DECERR, data 0.
  function automatic logic [1:0] ram_resp(input logic [31:0] a);
    return (a >= 32'h0800_0000) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    if (a >= 32'h0800_0000) return 32'h0;
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE} ^ 32'h1357_9BDF;
  endfunction

  // Every aligned word from floor(begin) up to floor(end), exclusive, in order.
  function automatic void model_dump(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] a, ea;
    word_t       w;
    int          i;
    exp_words.delete();
    exp_addrs.delete();
    exp_err = 1'b0;
    a  = b & 32'hFFFF_FFFC;
    ea = e & 32'hFFFF_FFFC;
    i  = 0;
    while (a < ea) begin
      w.data  = ram_data(a);
      w.index = 24'(i);
      w.last  = (ea - a == 32'd4);
      exp_words.push_back(w);
      exp_addrs.push_back(a);
      if (ram_resp(a) != 2'b00) exp_err = 1'b1;
      a += 32'd4;
      i++;
    end
  endfunction

  // Slave / consumer knobs and recorded traffic
  bit          stall = 1'b0;
  int          hold_idx = 0;
  int          hold_left = 0;
  word_t       words_q[$];
  logic [31:0] ar_q[$];
  int done_cnt, busy_cycles, overlap_cnt, ar_unstable, sig_unstable;
  int sv_cycles, ar_cycles, ar_during_hold;

  bit          s_busy, ar_fire, r_fire, ar_pend, sig_pend, in_hold;
  int          s_wait;
  logic [31:0] s_addr, ar_addr_l, ar_pend_addr;
  logic [56:0] sig_pend_w;
  word_t       mon_w;

  // Inputs chosen here are held through the next rising edge, so a handshake
  // is decided from the current outputs and the inputs just chosen.
  always @(negedge clk) begin
    if (rst) begin
      s_busy = 1'b0; s_wait = 0; ar_fire = 1'b0; r_fire = 1'b0;
      ar_pend = 1'b0; sig_pend = 1'b0;
      m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0;
      m_axil_rresp = 2'b00; sig_ready = 1'b0;
    end else begin
      if (r_fire) begin
        m_axil_rvalid = 1'b0;
        s_busy = 1'b0;
      end
      if (ar_fire) begin
        s_busy = 1'b1;
        s_addr = ar_addr_l;
        s_wait = stall ? int'($urandom_range(0, 3)) : 0;
      end
      if (s_busy && !m_axil_rvalid) begin
        if (s_wait > 0) s_wait--;
        else begin
          m_axil_rvalid = 1'b1;
          m_axil_rdata  = ram_data(s_addr);
          m_axil_rresp  = ram_resp(s_addr);
        end
      end
      m_axil_arready = s_busy ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      in_hold = 1'b0;
      if (sig_valid && hold_left > 0 && sig_index == 24'(hold_idx)) begin
        sig_ready = 1'b0;
        hold_left--;
        in_hold = 1'b1;
      end else begin
        sig_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (ar_pend && (!m_axil_arvalid || m_axil_araddr != ar_pend_addr)) ar_unstable++;
      if (sig_pend && (!sig_valid || {sig_data, sig_index, sig_last} != sig_pend_w))
        sig_unstable++;
      ar_fire      = m_axil_arvalid && m_axil_arready;
      r_fire       = m_axil_rvalid && m_axil_rready;
      ar_pend      = m_axil_arvalid && !m_axil_arready;
      ar_pend_addr = m_axil_araddr;
      sig_pend     = sig_valid && !sig_ready;
      sig_pend_w   = {sig_data, sig_index, sig_last};
      if (ar_fire) begin
        ar_addr_l = m_axil_araddr;
        ar_q.push_back(m_axil_araddr);
      end
      if (sig_valid && sig_ready) begin
        mon_w.data = sig_data; mon_w.index = sig_index; mon_w.last = sig_last;
        words_q.push_back(mon_w);
      end
      if (m_axil_arvalid && sig_valid) overlap_cnt++;
      if (in_hold && m_axil_arvalid) ar_during_hold++;
      if (m_axil_arvalid) ar_cycles++;
      if (sig_valid) sv_cycles++;
      if (done) done_cnt++;
      if (busy) busy_cycles++;
    end
  end

  task automatic clear_log();
    words_q.delete(); ar_q.delete();
    done_cnt = 0; busy_cycles = 0; overlap_cnt = 0; ar_unstable = 0; sig_unstable = 0;
    sv_cycles = 0; ar_cycles = 0; ar_during_hold = 0;
  endtask

  // Pulses start and waits (bounded) for done; lat counts cycles after the start cycle.
  task automatic do_dump(input logic [31:0] b, input logic [31:0] e, input int limit,
                         output int lat, output bit timeout);
    @(negedge clk);
    clear_log();
    sig_begin = b; sig_end = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; timeout = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, m_axil_arvalid, m_axil_rready, sig_valid, sig_last} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, done, error, m_axil_arvalid, m_axil_rready, sig_valid, sig_last});
    end
    checks++;
    if (sig_index !== 24'd0 || sig_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_sig: got idx=%h data=%h expected 0/0", sig_index, sig_data);
    end
    checks++;
    if (m_axil_araddr !== 32'd0 || m_axil_arprot !== 3'd0) begin
      errors++;
      $display("FAIL reset_ar: got addr=%h prot=%h expected 0/0", m_axil_araddr, m_axil_arprot);
    end
    checks++;
    if ({m_axil_awaddr, m_axil_awprot, m_axil_awvalid, m_axil_wdata, m_axil_wstrb,
         m_axil_wvalid, m_axil_bready} !== {32'd0, 3'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_write_idle: got aw=%h awv=%b w=%h strb=%h wv=%b bready=%b expected idle",
               m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb, m_axil_wvalid,
               m_axil_bready);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit to;
    stall = 1'b0;
    model_dump(32'h1000, 32'h1010);
    do_dump(32'h1000, 32'h1010, 200, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (words_q.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d expected 4", words_q.size());
    end
    for (int i = 0; i < exp_words.size(); i++) begin
      word_t g;
      g = '0;
      if (i < words_q.size()) g = words_q[i];
      checks++;
      if (g !== exp_words[i]) begin
        errors++; $display("FAIL basic_word%0d: got %h expected %h", i, g, exp_words[i]);
      end
    end
    checks++;
    if (ar_q != exp_addrs) begin
      errors++; $display("FAIL basic_araddr: got %p expected %p", ar_q, exp_addrs);
    end
    checks++;
    if (done_cnt != 1 || error !== 1'b0) begin
      errors++; $display("FAIL basic_done_err: got done=%0d err=%b expected 1/0", done_cnt, error);
    end
    // Zero-wait: AR, R, OUT per word plus the FIN cycle.
    checks++;
    if (lat != 13 || busy_cycles != 13) begin
      errors++; $display("FAIL basic_cycles: got lat=%0d busy=%0d expected 13/13", lat, busy_cycles);
    end
  endtask

  task automatic test_empty();
    int lat; bit to;
    stall = 1'b0;
    do_dump(32'h2000, 32'h2000, 20, lat, to);
    // Counting the start cycle as cycle 1, done is high in cycle 2.
    checks++;
    if (to || lat != 1) begin
      errors++; $display("FAIL empty_done_latency: got to=%b lat=%0d expected 0/1", to, lat);
    end
    checks++;
    if (sv_cycles != 0 || ar_cycles != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL empty_traffic: got sv=%0d ar=%0d done=%0d expected 0/0/1",
               sv_cycles, ar_cycles, done_cnt);
    end
  endtask

  task automatic test_unaligned();
    int lat; bit to;
    stall = 1'b0;
    model_dump(32'h1003, 32'h1009);
    do_dump(32'h1003, 32'h1009, 200, lat, to);
    checks++;
    if (to || ar_q.size() != 2 || ar_q[0] !== 32'h1000 || ar_q[1] !== 32'h1004) begin
      errors++; $display("FAIL unaligned_araddr: got %p expected 1000,1004", ar_q);
    end
    checks++;
    if (words_q.size() != 2 || words_q != exp_words) begin
      errors++; $display("FAIL unaligned_words: got %p expected %p", words_q, exp_words);
    end
  endtask

  task automatic test_backpressure();
    bit seen, to; logic [31:0] held;
    stall = 1'b0;
    model_dump(32'h1000, 32'h1010);
    @(negedge clk);
    clear_log();
    hold_idx = 1; hold_left = 20;
    sig_begin = 32'h1000; sig_end = 32'h1010; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 1'b0; held = '0;
    for (int i = 0; i < 50; i++) begin
      if (sig_valid && sig_index == 24'd1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    held = sig_data;
    // A start while busy must be ignored.
    sig_begin = 32'h3000; sig_end = 32'h3100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || to) begin
      errors++; $display("FAIL bp_progress: got seen=%b to=%b expected 1/0", seen, to);
    end
    checks++;
    if (held !== exp_words[1].data) begin
      errors++; $display("FAIL bp_held_data: got %h expected %h", held, exp_words[1].data);
    end
    checks++;
    if (sig_unstable != 0 || ar_during_hold != 0 || ar_unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: got sig=%0d arhold=%0d ar=%0d expected 0/0/0",
               sig_unstable, ar_during_hold, ar_unstable);
    end
    checks++;
    if (words_q != exp_words || ar_q != exp_addrs || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_result: got words=%p ar=%p done=%0d expected %p %p 1",
               words_q, ar_q, done_cnt, exp_words, exp_addrs);
    end
    hold_left = 0;
  endtask

  task automatic test_decerr();
    int lat; bit to;
    stall = 1'b0;
    model_dump(32'h0800_0000, 32'h0800_0004);
    do_dump(32'h0800_0000, 32'h0800_0004, 100, lat, to);
    checks++;
    if (to || done_cnt != 1) begin
      errors++; $display("FAIL decerr_done: got to=%b done=%0d expected 0/1", to, done_cnt);
    end
    checks++;
    if (words_q != exp_words || words_q.size() != 1) begin
      errors++; $display("FAIL decerr_word: got %p expected %p", words_q, exp_words);
    end
    // Sampled several cycles after done: the flag is sticky.
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL decerr_error: got %b expected 1", error);
    end
  endtask

  task automatic test_wrap();
    int lat; bit to;
    stall = 1'b0;
    model_dump(32'hFFFF_FFF0, 32'hFFFF_FFFF);
    do_dump(32'hFFFF_FFF0, 32'hFFFF_FFFF, 100, lat, to);
    checks++;
    if (to || done_cnt != 1) begin
      errors++; $display("FAIL wrap_done: got to=%b done=%0d expected 0/1", to, done_cnt);
    end
    checks++;
    if (words_q != exp_words || ar_q != exp_addrs || exp_words.size() != 3) begin
      errors++;
      $display("FAIL wrap_words: got %p ar=%p expected %p ar=%p", words_q, ar_q, exp_words,
               exp_addrs);
    end
    checks++;
    if (error !== exp_err) begin
      errors++; $display("FAIL wrap_error: got %b expected %b", error, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, to; int lat;
    stall = 1'b0;
    @(negedge clk);
    clear_log();
    sig_begin = 32'h1000; sig_end = 32'h1020; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_axil_rready && sig_index == 24'd2) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_reach_r2: got no R state expected R on word 2"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, error, m_axil_arvalid, m_axil_rready, sig_valid, sig_last} !== 7'b0 ||
        sig_index !== 24'd0 || sig_data !== 32'd0 || m_axil_araddr !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got flags=%b idx=%h data=%h addr=%h expected all 0",
               {busy, done, error, m_axil_arvalid, m_axil_rready, sig_valid, sig_last},
               sig_index, sig_data, m_axil_araddr);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_done: got done=%0d busy=%b expected 0/0", done_cnt, busy);
    end
    model_dump(32'h1000, 32'h1010);
    do_dump(32'h1000, 32'h1010, 200, lat, to);
    checks++;
    if (to || done_cnt != 1 || words_q != exp_words || error !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart: got to=%b done=%0d words=%p err=%b expected 0 1 %p 0",
               to, done_cnt, words_q, error, exp_words);
    end
  endtask

  task automatic test_random();
    int lat; bit to; logic [31:0] b, e;
    stall = 1'b1;
    for (int it = 0; it < 8; it++) begin
      b = 32'h4000 + $urandom_range(0, 80);
      e = (it == 3) ? b - $urandom_range(0, 8) : b + $urandom_range(0, 40);
      model_dump(b, e);
      do_dump(b, e, 800, lat, to);
      checks++;
      if (to || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_done: got to=%b done=%0d expected 0/1 (b=%h e=%h)",
                 it, to, done_cnt, b, e);
      end
      checks++;
      if (words_q != exp_words || ar_q != exp_addrs) begin
        errors++;
        $display("FAIL rand%0d_words: got %p ar=%p expected %p ar=%p",
                 it, words_q, ar_q, exp_words, exp_addrs);
      end
      checks++;
      if (error !== exp_err || overlap_cnt != 0 || ar_unstable != 0 || sig_unstable != 0) begin
        errors++;
        $display("FAIL rand%0d_proto: got err=%b ovl=%0d aru=%0d sgu=%0d expected %b/0/0/0",
                 it, error, overlap_cnt, ar_unstable, sig_unstable, exp_err);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; sig_begin = '0; sig_end = '0;
    clear_log();
    mem[32'h1000] = 32'hA0;
    mem[32'h1004] = 32'hA1;
    mem[32'h1008] = 32'hA2;
    mem[32'h100C] = 32'hA3;
    test_reset();
    test_basic();
    test_empty();
    test_unaligned();
    test_backpressure();
    test_decerr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
